uart_reg_bank: RTL and testbench

- Parametrised successor to the single-coefficient UART memory path.
- Takes received bytes from the UART, parses framed write/read commands and holds N_REGS coefficient registers of REG_WIDTH bits each (P, I, D, setpoint, ...).
- Commits each register atomically and returns an ACK, NAK or readback frame to the UART transmitter.
- Sits between UART and the PID datapath.

---
 rtl/uart_reg_bank.sv | 254 +++++++++++++++++++++++++
 tb/tb_uart_reg_bank.sv | 382 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_reg_bank.sv
// UART command parser and coefficient register bank: framed write/read commands,
// atomic register commits and ACK/NAK/readback responses back to the transmitter.
module uart_reg_bank #(
    parameter int         N_REGS         = 4,
    parameter int         REG_WIDTH      = 16,
    parameter logic [7:0] SYNC_BYTE      = 8'hA5,
    parameter int         TIMEOUT_CYCLES = 100000
) (
    input  logic                        clk_in,
    input  logic                        reset,
    input  logic                        data_rdy,
    input  logic [7:0]                  data_in,
    output logic                        tx_valid,
    input  logic                        tx_ready,
    output logic [7:0]                  tx_byte,
    output logic [N_REGS*REG_WIDTH-1:0] regs,
    output logic [N_REGS-1:0]           reg_update,
    output logic                        err_csum,
    output logic                        err_timeout,
    output logic                        err_overrun
);

    localparam int BYTES  = (REG_WIDTH + 7) / 8;
    localparam int SH_W   = BYTES * 8;
    localparam int RESP_N = BYTES + 1;
    localparam int IDX_W  = $clog2(RESP_N);
    localparam int CNT_W  = (BYTES > 1) ? $clog2(BYTES) : 1;
    localparam int TO_W   = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [7:0]       ACK_BYTE      = 8'h06;
    localparam logic [7:0]       NAK_BYTE      = 8'h15;
    localparam logic [TO_W-1:0]  TO_LAST       = TO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_LAST      = CNT_W'(BYTES - 1);
    localparam logic [IDX_W-1:0] IDX_READ_LAST = IDX_W'(BYTES);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CMD,
        S_DATA,
        S_CSUM,
        S_COMMIT,
        S_RESP
    } state_t;

    state_t           state_reg, state_next;
    logic [7:0]       cmd_reg, cmd_next;
    logic [7:0]       xor_reg, xor_next;
    logic [SH_W-1:0]  shadow_reg, shadow_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic [TO_W-1:0]  timer_reg, timer_next;
    logic [IDX_W-1:0] resp_idx_reg, resp_idx_next;
    logic [IDX_W-1:0] resp_last_reg;
    logic [7:0]       resp_buf_reg [RESP_N];
    logic             err_csum_reg, err_csum_next;
    logic             err_timeout_reg, err_timeout_next;
    logic             err_overrun_reg;

    logic [6:0]       addr;
    logic             addr_ok;
    logic             load_en, load_read, load_ack;
    logic [IDX_W-1:0] load_last;
    logic [7:0]       load_bytes [RESP_N];
    logic [7:0]       load_xor;
    logic [REG_WIDTH-1:0] rd_value;
    logic [SH_W-1:0]  rd_pad;

    assign addr    = cmd_reg[6:0];
    assign addr_ok = (int'(addr) < N_REGS);

    // Register storage: each entry only changes in the COMMIT cycle.
    generate
        for (genvar gi = 0; gi < N_REGS; gi++) begin : g_reg
            logic [REG_WIDTH-1:0] value_reg;
            logic                 hit;

            assign hit = (state_reg == S_COMMIT) && (addr == 7'(gi));

            always_ff @(posedge clk_in) begin
                if (reset) begin
                    value_reg <= '0;
                end else if (hit) begin
                    value_reg <= shadow_reg[REG_WIDTH-1:0];
                end
            end

            assign regs[gi*REG_WIDTH +: REG_WIDTH] = value_reg;
            assign reg_update[gi]                  = hit;
        end
    endgenerate

    // Response image: readback bytes MSB first plus trailing XOR, or a single ACK/NAK.
    always_comb begin
        rd_value = '0;
        for (int k = 0; k < N_REGS; k++) begin
            if (addr == 7'(k)) begin
                rd_value = regs[k*REG_WIDTH +: REG_WIDTH];
            end
        end
        rd_pad                 = '0;
        rd_pad[REG_WIDTH-1:0]  = rd_value;
        load_xor               = '0;
        load_last              = '0;
        for (int i = 0; i < RESP_N; i++) begin
            load_bytes[i] = '0;
        end
        if (load_read) begin
            for (int i = 0; i < BYTES; i++) begin
                load_bytes[i] = rd_pad[(BYTES-1-i)*8 +: 8];
                load_xor      = load_xor ^ rd_pad[(BYTES-1-i)*8 +: 8];
            end
            load_bytes[BYTES] = load_xor;
            load_last         = IDX_READ_LAST;
        end else begin
            load_bytes[0] = load_ack ? ACK_BYTE : NAK_BYTE;
        end
    end

    always_comb begin
        state_next       = state_reg;
        cmd_next         = cmd_reg;
        xor_next         = xor_reg;
        shadow_next      = shadow_reg;
        cnt_next         = cnt_reg;
        timer_next       = timer_reg;
        resp_idx_next    = resp_idx_reg;
        load_en          = 1'b0;
        load_read        = 1'b0;
        load_ack         = 1'b0;
        err_csum_next    = 1'b0;
        err_timeout_next = 1'b0;

        case (state_reg)
            S_IDLE: begin
                if (data_rdy && (data_in == SYNC_BYTE)) begin
                    state_next = S_CMD;
                    timer_next = '0;
                end
            end
            S_CMD, S_DATA, S_CSUM: begin
                if (data_rdy) begin
                    timer_next = '0;
                    if (state_reg == S_CMD) begin
                        cmd_next    = data_in;
                        xor_next    = data_in;
                        cnt_next    = '0;
                        shadow_next = '0;
                        state_next  = data_in[7] ? S_DATA : S_CSUM;
                    end else if (state_reg == S_DATA) begin
                        shadow_next = (shadow_reg << 8) | SH_W'(data_in);
                        xor_next    = xor_reg ^ data_in;
                        cnt_next    = cnt_reg + CNT_W'(1);
                        if (cnt_reg == CNT_LAST) begin
                            state_next = S_CSUM;
                        end
                    end else begin
                        resp_idx_next = '0;
                        if (data_in != xor_reg) begin
                            err_csum_next = 1'b1;
                            load_en       = 1'b1;
                            state_next    = S_RESP;
                        end else if (!addr_ok) begin
                            load_en    = 1'b1;
                            state_next = S_RESP;
                        end else if (cmd_reg[7]) begin
                            state_next = S_COMMIT;
                        end else begin
                            load_en    = 1'b1;
                            load_read  = 1'b1;
                            state_next = S_RESP;
                        end
                    end
                end else if (timer_reg == TO_LAST) begin
                    // Abandon the partial frame silently.
                    err_timeout_next = 1'b1;
                    shadow_next      = '0;
                    timer_next       = '0;
                    state_next       = S_IDLE;
                end else begin
                    timer_next = timer_reg + TO_W'(1);
                end
            end
            S_COMMIT: begin
                load_en       = 1'b1;
                load_ack      = 1'b1;
                resp_idx_next = '0;
                state_next    = S_RESP;
            end
            S_RESP: begin
                if (tx_ready) begin
                    if (resp_idx_reg == resp_last_reg) begin
                        state_next = S_IDLE;
                    end else begin
                        resp_idx_next = resp_idx_reg + IDX_W'(1);
                    end
                end
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (reset) begin
            state_reg       <= S_IDLE;
            cmd_reg         <= '0;
            xor_reg         <= '0;
            shadow_reg      <= '0;
            cnt_reg         <= '0;
            timer_reg       <= '0;
            resp_idx_reg    <= '0;
            resp_last_reg   <= '0;
            err_csum_reg    <= 1'b0;
            err_timeout_reg <= 1'b0;
            err_overrun_reg <= 1'b0;
        end else begin
            state_reg       <= state_next;
            cmd_reg         <= cmd_next;
            xor_reg         <= xor_next;
            shadow_reg      <= shadow_next;
            cnt_reg         <= cnt_next;
            timer_reg       <= timer_next;
            resp_idx_reg    <= resp_idx_next;
            err_csum_reg    <= err_csum_next;
            err_timeout_reg <= err_timeout_next;
            if (load_en) begin
                resp_last_reg <= load_last;
            end
            // Bytes arriving while a response is pending are lost; remember that.
            if (data_rdy && ((state_reg == S_COMMIT) || (state_reg == S_RESP))) begin
                err_overrun_reg <= 1'b1;
            end
        end
    end

    generate
        for (genvar gi = 0; gi < RESP_N; gi++) begin : g_resp
            always_ff @(posedge clk_in) begin
                if (reset) begin
                    resp_buf_reg[gi] <= '0;
                end else if (load_en) begin
                    resp_buf_reg[gi] <= load_bytes[gi];
                end
            end
        end
    endgenerate

    assign tx_valid    = (state_reg == S_RESP);
    assign tx_byte     = (state_reg == S_RESP) ? resp_buf_reg[resp_idx_reg] : 8'h00;
    assign err_csum    = err_csum_reg;
    assign err_timeout = err_timeout_reg;
    assign err_overrun = err_overrun_reg;

endmodule

// File: tb/tb_uart_reg_bank.sv
// Bench for uart_reg_bank: directed frames plus randomized traffic, checked every
// cycle against a frame-level model of registers and expected response bytes.
module tb_uart_reg_bank;

    localparam int N_REGS    = 4;
    localparam int REG_WIDTH = 16;
    localparam int TIMEOUT   = 50;

    logic        clk_in = 1'b0;
    logic        reset;
    logic        data_rdy;
    logic [7:0]  data_in;
    logic        tx_valid;
    logic        tx_ready;
    logic [7:0]  tx_byte;
    logic [63:0] regs;
    logic [3:0]  reg_update;
    logic        err_csum;
    logic        err_timeout;
    logic        err_overrun;

    always #5 clk_in = ~clk_in;

    uart_reg_bank #(
        .N_REGS         (N_REGS),
        .REG_WIDTH      (REG_WIDTH),
        .SYNC_BYTE      (8'hA5),
        .TIMEOUT_CYCLES (TIMEOUT)
    ) dut (
        .clk_in      (clk_in),
        .reset       (reset),
        .data_rdy    (data_rdy),
        .data_in     (data_in),
        .tx_valid    (tx_valid),
        .tx_ready    (tx_ready),
        .tx_byte     (tx_byte),
        .regs        (regs),
        .reg_update  (reg_update),
        .err_csum    (err_csum),
        .err_timeout (err_timeout),
        .err_overrun (err_overrun)
    );

    int          total = 0;
    int          bad   = 0;
    logic [15:0] model_regs [4];
    logic [7:0]  exp_q [$];
    logic [7:0]  frame_q [$];
    bit          commit_pending;
    int          commit_addr;
    logic [15:0] commit_val;
    int          apply_addr = -1;
    logic [15:0] apply_val;
    int          csum_pulses, to_pulses, upd_pulses;
    bit          exp_overrun;
    bit          use_manual;
    logic        man_val;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [63:0] model_pack();
        return {model_regs[3], model_regs[2], model_regs[1], model_regs[0]};
    endfunction

    // Readback frame for a register: high byte, low byte, XOR of both.
    function automatic logic [23:0] model_read_resp(input int a);
        int v, hi, lo;
        v  = int'(model_regs[a]);
        hi = v / 256;
        lo = v % 256;
        return {8'(hi), 8'(lo), 8'(hi ^ lo)};
    endfunction

    task automatic clear_counts();
        csum_pulses = 0;
        to_pulses   = 0;
        upd_pulses  = 0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(posedge clk_in);
        #1;
        data_rdy = 1'b1;
        data_in  = b;
        @(posedge clk_in);
        #1;
        data_rdy = 1'b0;
    endtask

    task automatic send_frame();
        for (int i = 0; i < frame_q.size(); i++) begin
            send_byte(frame_q[i]);
            repeat ($urandom_range(0, 3)) @(posedge clk_in);
        end
    endtask

    task automatic wait_resp();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 500) begin
            @(negedge clk_in);
            n++;
        end
        check("resp_complete", 64'(exp_q.size()), 64'd0);
        repeat (3) @(negedge clk_in);
        check("tx_idle_after_resp", 64'(tx_valid), 64'd0);
    endtask

    task automatic end_frame(input int ec, input int eu);
        check("err_csum_count", 64'(csum_pulses), 64'(ec));
        check("reg_update_count", 64'(upd_pulses), 64'(eu));
        check("err_timeout_count", 64'(to_pulses), 64'd0);
    endtask

    task automatic do_reset();
        @(posedge clk_in);
        #1;
        reset = 1'b1;
        for (int i = 0; i < N_REGS; i++) model_regs[i] = '0;
        exp_q.delete();
        commit_pending = 1'b0;
        exp_overrun    = 1'b0;
        repeat (2) @(posedge clk_in);
        #1;
        reset = 1'b0;
    endtask

    task automatic wait_tx_valid(input string name);
        int n;
        n = 0;
        @(negedge clk_in);
        while (!tx_valid && n < 60) begin
            @(negedge clk_in);
            n++;
        end
        check(name, 64'(tx_valid), 64'd1);
    endtask

    // Transmitter handshake: random acceptance unless the test takes control.
    initial begin
        tx_ready = 1'b0;
        forever begin
            @(posedge clk_in);
            #1;
            tx_ready = use_manual ? man_val : ($urandom_range(0, 3) != 0);
        end
    end

    // Per-cycle compare against the model.
    initial begin
        logic       pv, pr, po;
        logic [7:0] pb;
        pv = 1'b0; pr = 1'b0; po = 1'b0; pb = '0;
        forever begin
            @(negedge clk_in);
            if (reset) begin
                pv = 1'b0; pr = 1'b0; po = 1'b0;
                apply_addr = -1;
            end else begin
                if (apply_addr >= 0) begin
                    model_regs[apply_addr] = apply_val;
                    apply_addr = -1;
                end
                check("regs", regs, model_pack());
                if (reg_update != 0) begin
                    upd_pulses++;
                    if (commit_pending) begin
                        check("reg_update", 64'(reg_update), 64'd1 << commit_addr);
                        apply_addr     = commit_addr;
                        apply_val      = commit_val;
                        commit_pending = 1'b0;
                    end else begin
                        check("reg_update_unexpected", 64'(reg_update), 64'd0);
                    end
                end
                if (err_csum) csum_pulses++;
                if (err_timeout) to_pulses++;
                if (!exp_overrun) check("err_overrun_clear", 64'(err_overrun), 64'd0);
                if (po) check("err_overrun_sticky", 64'(err_overrun), 64'd1);
                if (pv && !pr) begin
                    check("tx_valid_hold", 64'(tx_valid), 64'd1);
                    check("tx_byte_hold", 64'(tx_byte), 64'(pb));
                end
                if (tx_valid && tx_ready) begin
                    if (exp_q.size() == 0) check("tx_unexpected", 64'(tx_valid), 64'd0);
                    else check("tx_byte", 64'(tx_byte), 64'(exp_q.pop_front()));
                end
                pv = tx_valid; pr = tx_ready; pb = tx_byte; po = err_overrun;
            end
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: time limit reached, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [23:0] rr;
        reset = 1'b1; data_rdy = 1'b0; data_in = '0;
        use_manual = 1'b0; man_val = 1'b0;
        commit_pending = 1'b0; exp_overrun = 1'b0;
        for (int i = 0; i < N_REGS; i++) model_regs[i] = '0;
        clear_counts();
        repeat (3) @(posedge clk_in);
        #1;
        reset = 1'b0;
        @(negedge clk_in);
        check("rst_tx_valid", 64'(tx_valid), 64'd0);
        check("rst_tx_byte", 64'(tx_byte), 64'd0);
        check("rst_regs", regs, 64'd0);
        check("rst_reg_update", 64'(reg_update), 64'd0);
        check("rst_err_csum", 64'(err_csum), 64'd0);
        check("rst_err_timeout", 64'(err_timeout), 64'd0);
        check("rst_err_overrun", 64'(err_overrun), 64'd0);

        // Write reg 2 = 1234
        clear_counts();
        commit_pending = 1'b1; commit_addr = 2; commit_val = 16'h1234;
        exp_q.push_back(8'h06);
        frame_q = {8'hA5, 8'h82, 8'h12, 8'h34, 8'hA4};
        send_frame(); wait_resp(); end_frame(0, 1);
        check("wr2_value", 64'(regs[47:32]), 64'h1234);
        check("wr2_others", {16'h0, regs[63:48], regs[31:0]}, 64'd0);

        // Bad checksum
        clear_counts();
        exp_q.push_back(8'h15);
        frame_q = {8'hA5, 8'h82, 8'h55, 8'h66, 8'h00};
        send_frame(); wait_resp(); end_frame(1, 0);
        check("badcs_value", 64'(regs[47:32]), 64'h1234);

        // Read reg 2 with a stalled second byte
        clear_counts();
        rr = model_read_resp(2);
        check("model_read_pin", 64'(rr), 64'h123426);
        use_manual = 1'b1; man_val = 1'b0;
        exp_q.push_back(8'h12); exp_q.push_back(8'h34); exp_q.push_back(8'h26);
        frame_q = {8'hA5, 8'h02, 8'h02};
        send_frame();
        wait_tx_valid("rd_first_valid");
        check("rd_first_byte", 64'(tx_byte), 64'h12);
        man_val = 1'b1;
        @(negedge clk_in);
        man_val = 1'b0;
        @(negedge clk_in);
        for (int i = 0; i < 5; i++) begin
            check("stall_valid", 64'(tx_valid), 64'd1);
            check("stall_byte", 64'(tx_byte), 64'h34);
            @(negedge clk_in);
        end
        man_val = 1'b1;
        wait_resp(); end_frame(0, 0);
        use_manual = 1'b0;

        // Out-of-range write
        clear_counts();
        exp_q.push_back(8'h15);
        frame_q = {8'hA5, 8'h85, 8'h00, 8'h01, 8'h84};
        send_frame(); wait_resp(); end_frame(0, 0);
        check("oor_regs", regs, 64'h0000_1234_0000_0000);

        // Inter-byte timeout, then a clean write of reg 0
        clear_counts();
        frame_q = {8'hA5, 8'h82, 8'h12};
        send_frame();
        repeat (80) @(negedge clk_in);
        check("timeout_pulses", 64'(to_pulses), 64'd1);
        check("timeout_no_tx", 64'(tx_valid), 64'd0);
        clear_counts();
        commit_pending = 1'b1; commit_addr = 0; commit_val = 16'hBEEF;
        exp_q.push_back(8'h06);
        frame_q = {8'hA5, 8'h80, 8'hBE, 8'hEF, 8'hD1};
        send_frame(); wait_resp(); end_frame(0, 1);
        check("beef_value", 64'(regs[15:0]), 64'hBEEF);
        check("after_timeout_regs", regs, 64'h0000_1234_0000_BEEF);

        // Byte during response: overrun, and the SYNC is not a frame start
        clear_counts();
        use_manual = 1'b1; man_val = 1'b0;
        commit_pending = 1'b1; commit_addr = 1; commit_val = 16'h5A5A;
        exp_q.push_back(8'h06);
        frame_q = {8'hA5, 8'h81, 8'h5A, 8'h5A, 8'h81};
        send_frame();
        wait_tx_valid("ovr_resp_valid");
        exp_overrun = 1'b1;
        send_byte(8'hA5);
        @(negedge clk_in);
        check("ovr_set", 64'(err_overrun), 64'd1);
        man_val = 1'b1;
        wait_resp(); end_frame(0, 1);
        use_manual = 1'b0;
        clear_counts();
        frame_q = {8'h02, 8'h02};
        send_frame();
        repeat (20) @(negedge clk_in);
        check("ovr_no_frame", 64'(tx_valid), 64'd0);
        end_frame(0, 0);
        clear_counts();
        exp_q.push_back(8'h5A); exp_q.push_back(8'h5A); exp_q.push_back(8'h00);
        frame_q = {8'hA5, 8'h01, 8'h01};
        send_frame(); wait_resp(); end_frame(0, 0);
        check("ovr_still_set", 64'(err_overrun), 64'd1);

        // Reset in the middle of a write frame
        clear_counts();
        frame_q = {8'hA5, 8'h82, 8'h12};
        send_frame();
        do_reset();
        repeat (20) @(negedge clk_in);
        check("mid_rst_regs", regs, 64'd0);
        check("mid_rst_overrun", 64'(err_overrun), 64'd0);
        check("mid_rst_tx", 64'(tx_valid), 64'd0);
        end_frame(0, 0);
        clear_counts();
        commit_pending = 1'b1; commit_addr = 3; commit_val = 16'hC3A5;
        exp_q.push_back(8'h06);
        frame_q = {8'hA5, 8'h83, 8'hC3, 8'hA5, 8'hE5};
        send_frame(); wait_resp(); end_frame(0, 1);
        check("post_rst_write", 64'(regs[63:48]), 64'hC3A5);

        // Randomized traffic
        for (int f = 0; f < 150; f++) begin
            logic [6:0]  a;
            logic        wr, corrupt;
            logic [15:0] d;
            logic [7:0]  cmd, cs, junk;
            int          ec, eu;
            a       = 7'($urandom_range(0, 5));
            wr      = 1'($urandom_range(0, 1));
            d       = 16'($urandom);
            if ($urandom_range(0, 7) == 0) d[15:8] = 8'hA5;
            if ($urandom_range(0, 7) == 0) d[7:0]  = 8'hA5;
            cmd     = {wr, a};
            cs      = wr ? (cmd ^ d[15:8] ^ d[7:0]) : cmd;
            corrupt = ($urandom_range(0, 5) == 0);
            if (corrupt) cs = cs ^ (8'h01 << $urandom_range(0, 7));
            clear_counts();
            ec = 0; eu = 0;
            frame_q.delete();
            if ($urandom_range(0, 7) == 0) begin
                junk = 8'($urandom_range(0, 255));
                if (junk == 8'hA5) junk = 8'h5A;
                frame_q.push_back(junk);
            end
            frame_q.push_back(8'hA5);
            frame_q.push_back(cmd);
            if (wr) begin
                frame_q.push_back(d[15:8]);
                frame_q.push_back(d[7:0]);
            end
            frame_q.push_back(cs);
            if (corrupt) begin
                exp_q.push_back(8'h15);
                ec = 1;
            end else if (int'(a) >= N_REGS) begin
                exp_q.push_back(8'h15);
            end else if (wr) begin
                commit_pending = 1'b1; commit_addr = int'(a); commit_val = d;
                exp_q.push_back(8'h06);
                eu = 1;
            end else begin
                rr = model_read_resp(int'(a));
                exp_q.push_back(rr[23:16]);
                exp_q.push_back(rr[15:8]);
                exp_q.push_back(rr[7:0]);
            end
            send_frame(); wait_resp(); end_frame(ec, eu);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
